// File: rtl/univ_shift_reg_if.sv
// Command/data bundle for the universal shift register: START/S/N/D command side,
// serial fill inputs, rotate request, and the Q/BUSY/DONE status side.
interface univ_shift_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [1:0]       s;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] d;
    logic             sir;
    logic             sil;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output start, s, n, d, sir, sil, rot,
        input  q, busy, done
    );

    modport slave (
        input  start, s, n, d, sir, sil, rot,
        output q, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register (per-bit 4:1 mux) with a start/busy/done command FSM.
// Optional feature macro: SHREG_ROTATE_EN (rotate instead of serial fill when ROT latched high).
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    univ_shift_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             done_r;

    logic             fill_r_s;
    logic             fill_l_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] shl_s;
    logic [WIDTH-1:0] q_next_s;

    function automatic logic mux4(input logic [1:0] sel, input logic in0, input logic in1,
                                  input logic in2, input logic in3);
        logic y;
        case (sel)
            2'b00:   y = in0;
            2'b01:   y = in1;
            2'b10:   y = in2;
            default: y = in3;
        endcase
        return y;
    endfunction

`ifdef SHREG_ROTATE_EN
    logic rot_r;

    // Rotate request is captured with the command, like S and N.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rot_r <= 1'b0;
        end else if (state_r == ST_IDLE && bus.start) begin
            rot_r <= bus.rot;
        end else begin
            rot_r <= rot_r;
        end
    end

    // Fill bits come from the opposite end of the register while rotating.
    always_comb begin
        fill_r_s = bus.sir;
        fill_l_s = bus.sil;
        if (rot_r) begin
            fill_r_s = q_r[0];
            fill_l_s = q_r[WIDTH-1];
        end else begin
            fill_r_s = bus.sir;
            fill_l_s = bus.sil;
        end
    end
`else
    logic unused_rot_s;
    assign unused_rot_s = bus.rot;

    // Serial inputs are always the fill bits.
    always_comb begin
        fill_r_s = bus.sir;
        fill_l_s = bus.sil;
    end
`endif

    // Per-bit 4:1 mux selected by the latched mode code.
    always_comb begin
        shr_s    = {fill_r_s, q_r[WIDTH-1:1]};
        shl_s    = {q_r[WIDTH-2:0], fill_l_s};
        q_next_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            q_next_s[i] = mux4(mode_r, q_r[i], shr_s[i], shl_s[i], bus.d[i]);
        end
    end

    // Command FSM; Q, BUSY and DONE are all registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= 2'b00;
            cnt_r   <= CNT_ZERO;
            q_r     <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.s == 2'b11) begin
                            q_r     <= bus.d;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (bus.s == 2'b00 || bus.n == CNT_ZERO) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            mode_r  <= bus.s;
                            cnt_r   <= bus.n;
                            busy_r  <= 1'b1;
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus pushes expected Q/DONE cycle, a monitor
// pops on every DONE pulse. Reference model uses plain integer shifts.
module tb_univ_shift_reg;
    localparam int W  = 4;
    localparam int CW = 4;

    typedef struct {
        logic [W-1:0] q;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [W-1:0] model_q = '0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_q", 32'(bus.q), 32'(e.q));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Issue one command starting at a negedge; returns at a negedge with the FSM back in IDLE.
    task automatic cmd(input logic [1:0] s_i, input int n_i, input logic [W-1:0] d_i,
                       input logic rot_i, input int sir_i, input int sil_i);
        exp_t e;
        int   c0;
        logic f;
        logic rotate;
        c0        = cyc;
        bus.start = 1'b1;
        bus.s     = s_i;
        bus.n     = CW'(n_i);
        bus.d     = d_i;
        bus.rot   = rot_i;
        bus.sir   = 1'($urandom_range(0, 1));
        bus.sil   = 1'($urandom_range(0, 1));
        if (s_i == 2'b11 || s_i == 2'b00 || n_i == 0) begin
            if (s_i == 2'b11) model_q = d_i;
            e.q   = model_q;
            e.cyc = c0 + 1;
            exp_q.push_back(e);
            @(negedge clk);
            bus.start = 1'b0;
            check("busy_degenerate", 32'(bus.busy), 32'd0);
            @(negedge clk);
            return;
        end
        rotate = 1'b0;
`ifdef SHREG_ROTATE_EN
        rotate = rot_i;
`endif
        @(negedge clk);
        for (int j = 0; j < n_i; j++) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            check("q_run", 32'(bus.q), 32'(model_q));
            bus.start = 1'($urandom_range(0, 1));
            bus.s     = 2'($urandom);
            bus.n     = CW'($urandom);
            bus.d     = W'($urandom);
            bus.rot   = 1'($urandom_range(0, 1));
            bus.sir   = (sir_i < 0) ? 1'($urandom_range(0, 1)) : 1'(sir_i);
            bus.sil   = (sil_i < 0) ? 1'($urandom_range(0, 1)) : 1'(sil_i);
            if (s_i == 2'b01) begin
                f       = rotate ? model_q[0] : bus.sir;
                model_q = (model_q >> 1) | (W'(f) << (W - 1));
            end else begin
                f       = rotate ? model_q[W-1] : bus.sil;
                model_q = (model_q << 1) | W'(f);
            end
            if (j == n_i - 1) begin
                e.q   = model_q;
                e.cyc = c0 + 1 + n_i;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b1;
        bus.s     = 2'b11;
        bus.n     = CW'(3);
        bus.d     = 4'b1111;
        bus.sir   = 1'b0;
        bus.sil   = 1'b0;
        bus.rot   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        model_q   = '0;
        @(negedge clk);

        cmd(2'b11, 0, 4'b1010, 1'b0, -1, -1);
        check("plan_load", 32'(bus.q), 32'(4'b1010));
        cmd(2'b01, 3, 4'b0000, 1'b0, 1, -1);
        check("plan_shr", 32'(bus.q), 32'(4'b1111));
        cmd(2'b11, 0, 4'b0110, 1'b0, -1, -1);
        cmd(2'b10, 2, 4'b1111, 1'b0, -1, 0);
        check("plan_shl", 32'(bus.q), 32'(4'b1000));
        cmd(2'b00, 5, 4'b0101, 1'b0, -1, -1);
        cmd(2'b01, 0, 4'b0101, 1'b0, -1, -1);
        check("plan_hold", 32'(bus.q), 32'(4'b1000));
        cmd(2'b11, 0, 4'b1001, 1'b0, -1, -1);
        cmd(2'b01, 1, 4'b0000, 1'b1, 0, -1);
`ifdef SHREG_ROTATE_EN
        check("plan_rot", 32'(bus.q), 32'(4'b1100));
`else
        check("plan_rot", 32'(bus.q), 32'(4'b0100));
`endif

        // Abort: reset during the second cycle of an N=4 shift.
        cmd(2'b11, 0, 4'b1011, 1'b0, -1, -1);
        bus.start = 1'b1;
        bus.s     = 2'b01;
        bus.n     = CW'(4);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_q", 32'(bus.q), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst_n   = 1'b1;
        model_q = '0;
        @(negedge clk);
        cmd(2'b11, 0, 4'b0101, 1'b0, -1, -1);
        check("after_abort_load", 32'(bus.q), 32'(4'b0101));

        for (int i = 0; i < 40; i++) begin
            cmd(2'($urandom), $urandom_range(0, 15), W'($urandom),
                1'($urandom_range(0, 1)), -1, -1);
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Universal N-bit shift register built from one 4-to-1 multiplexer per bit. It sits directly downstream of the 4-to-1 mux block: each bit's next value is the mux output selected by the latched mode code. A small command FSM adds a start/busy/done handshake, so one command applies a parallel load or a programmed number of shifts. The block is the register stage of the shift-register lab datapath.

## Interface
Parameters:
- WIDTH, 4: register width in bits; minimum 2.
- CNT_W, 4: width of the shift-count input N.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  command strobe; sampled only in IDLE.
- S  in  2  mode code, same encoding as the bit-mux select:
  - 00: hold.
  - 01: shift right (toward LSB); MSB fills from SIR.
  - 10: shift left; LSB fills from SIL.
  - 11: parallel load.
- N  in  CNT_W  number of shift cycles; sampled with START.
- D  in  WIDTH  parallel load data; sampled with START.
- SIR  in  1  serial input for shift right; sampled on every shift edge.
- SIL  in  1  serial input for shift left; sampled on every shift edge.
- ROT  in  1  rotate request; used only when SHREG_ROTATE_EN is defined.
- Q  out  WIDTH  register contents.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse when a command completes.

## Operation
- Each bit Q[i] has a 4:1 mux. Inputs in select order 00..11 are: Q[i], Q[i+1] (or the right fill bit for the MSB), Q[i-1] (or the left fill bit for the LSB), D[i]. The select is the internal latched mode register.
- The FSM has three states:
  - IDLE:
    - START=1 with S=11: Q<=D, go to DONE.
    - START=1 with S=00, or with N=0: Q unchanged, go to DONE.
    - Otherwise on START=1: latch mode<=S and cnt<=N, go to RUN.
    - START=0: stay in IDLE; Q holds.
  - RUN:
    - Each edge applies one shift and decrements cnt.
    - When cnt==1 at an edge, apply the final shift and go to DONE.
  - DONE: DONE=1 for that cycle; go to IDLE on the next edge.
- START in RUN or DONE is ignored. There is no queueing.
- S, N and D changing during RUN has no effect; the values latched at START are used.
- SIR/SIL are not latched; the live value at each shift edge is used.
- Reset values: Q=0, BUSY=0, DONE=0, state=IDLE, cnt=0, mode=00.
- Reset mid-RUN aborts the command. Q clears on that edge and no DONE pulse is produced.
- When RST_N=0 and START=1 on the same edge, reset wins.

## Timing
- START is accepted at edge k.
- Shift command (N≥1):
  - BUSY is high after edge k through edge k+N.
  - The N shifts occur at edges k+1..k+N.
  - DONE is high in the cycle after edge k+N.
  - The FSM is back in IDLE after edge k+N+1; the next START can be accepted at edge k+N+2.
- Load, hold, or N=0: Q updates (or holds) at edge k, DONE is high in the cycle after edge k, and BUSY stays low.
- Maximum count is 2^CNT_W−1 shifts. N≥WIDTH is legal: the register fully flushes to fill bits (or, with rotation enabled, wraps around repeatedly).

## Configuration
- SHREG_ROTATE_EN defined:
  - For shift commands, the ROT value latched at START selects rotation.
  - ROT=1 on shift right: MSB fills from Q[0].
  - ROT=1 on shift left: LSB fills from Q[WIDTH−1].
  - SIR/SIL are ignored while rotating.
- SHREG_ROTATE_EN undefined: ROT is ignored, SIR/SIL are always used as fill bits, and no rotate logic is present.

## Test plan
- Reset: RST_N=0 for 2 edges with START=1 → Q=0000, BUSY=0, DONE=0, no command accepted.
- Load: S=11, D=1010, START → Q=1010 after one edge, DONE pulses for one cycle, BUSY never rises.
- Shift right: from Q=1010, S=01, N=3, SIR=1 → Q=1101, then 1110, then 1111. BUSY is high for 3 cycles, then DONE pulses once. A START pulse mid-run is ignored.
- Shift left and degenerate commands:
  - From Q=0110, S=10, N=2, SIL=0 → Q=1100, then 1000.
  - S=00 with N=5, or S=01 with N=0 → Q unchanged, DONE in the cycle after START.
- Abort: RST_N=0 during the second cycle of an N=4 shift → Q=0000 on that edge, BUSY=0, no DONE pulse; a subsequent START works normally.
- Rotate: Q=1001, S=01, N=1, ROT=1, SIR=0.
  - With SHREG_ROTATE_EN → Q=1100.
  - Without it → Q=0100.
